text_console_ctrl: RTL and testbench

Byte-stream terminal controller that sits between the UART receiver and the character/attribute screen buffer. It turns received bytes into buffer writes. Printable bytes go to a hardware cursor with auto-advance and wrap; ESC-prefixed commands do positioned writes, cursor moves, attribute changes and a full-screen clear sweep. It generalises the fixed col/row/char/newline sequence to any grid size and adds a per-cell colour attribute.

---
 rtl/text_console_pkg.sv | 20 ++
 rtl/console_clear_sweep.sv | 42 ++++
 rtl/text_console_ctrl.sv | 144 ++++++++++++++
 tb/tb_text_console_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// text_console_pkg: states, control/opcode bytes and printable range for text_console_ctrl
package text_console_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ESC, S_P_COL, S_P_ROW, S_P_CHR, S_P_ATR, S_G_COL, S_G_ROW, S_A_ATR, S_CLEAR
  } state_t;
  localparam logic [7:0] C_ESC = 8'h1B;
  localparam logic [7:0] OP_P  = 8'h50;
  localparam logic [7:0] OP_G  = 8'h47;
  localparam logic [7:0] OP_A  = 8'h41;
  localparam logic [7:0] OP_C  = 8'h43;
  localparam logic [7:0] C_LF  = 8'h0A;
  localparam logic [7:0] C_CR  = 8'h0D;
  localparam logic [7:0] C_BS  = 8'h08;
  localparam logic [7:0] PR_LO = 8'h20;
  localparam logic [7:0] PR_HI = 8'h7E;
  localparam logic [7:0] FILL  = 8'h20;
  function automatic logic is_print(input logic [7:0] b);
    return b >= PR_LO && b <= PR_HI;
  endfunction
endpackage

// File: rtl/console_clear_sweep.sv
// console_clear_sweep: row-major col/row sweep over the whole grid, column fastest
// Ports: clk_i/rst_i clock and sync reset; start_i begins a sweep at (0,0);
//        busy_o high while sweeping; done_o high during the last cell; col_o/row_o current cell.
module console_clear_sweep #(
  parameter int N_COL = 80,
  parameter int N_ROW = 30,
  parameter int COL_W = 7,
  parameter int ROW_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o
);
  logic             r_busy;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_col_end;
  assign w_col_end = r_col == COL_W'(N_COL - 1);
  assign done_o    = r_busy && w_col_end && r_row == ROW_W'(N_ROW - 1);
  assign busy_o    = r_busy;
  assign col_o     = r_col;
  assign row_o     = r_row;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (start_i) begin
      r_busy <= 1'b1;
      r_col  <= '0;
      r_row  <= '0;
    end else if (r_busy) begin
      r_col <= w_col_end ? '0 : r_col + COL_W'(1);
      if (w_col_end) r_row <= done_o ? '0 : r_row + ROW_W'(1);
      if (done_o) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: UART byte stream to character/attribute buffer writes with cursor and ESC commands
// Ports: clk_i/rst_i clock and sync reset; rx_valid_i/rx_data_i UART byte (rising edge of valid accepted);
//        wr_en_o/col_o/row_o/char_o/attr_o buffer write; cur_col_o/cur_row_o cursor;
//        busy_o clear sweep active; overrun_o pulse for a byte dropped during the sweep.
module text_console_ctrl import text_console_pkg::*; #(
  parameter int                N_COL        = 80,
  parameter int                N_ROW        = 30,
  parameter int                COL_W        = 7,
  parameter int                ROW_W        = 5,
  parameter int                CHAR_W       = 7,
  parameter int                ATTR_W       = 8,
  parameter logic [ATTR_W-1:0] DEFAULT_ATTR = 8'h0F,
  parameter int                TIMEOUT_CYC  = 25_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              wr_en_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [CHAR_W-1:0] char_o,
  output logic [ATTR_W-1:0] attr_o,
  output logic [COL_W-1:0]  cur_col_o,
  output logic [ROW_W-1:0]  cur_row_o,
  output logic              busy_o,
  output logic              overrun_o
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  state_t             r_state, w_next;
  logic               r_prev, r_wr, r_ovr;
  logic [TO_W-1:0]    r_to;
  logic [COL_W-1:0]   r_ccol, r_col, r_pcol, w_clamp_col, w_scol;
  logic [ROW_W-1:0]   r_crow, r_row, r_prow, w_clamp_row, w_srow, w_row_inc;
  logic [CHAR_W-1:0]  r_chr, r_pchr;
  logic [ATTR_W-1:0]  r_attr, r_wattr;
  logic               w_acc, w_to, w_start, w_busy, w_done, w_col_end;
  assign w_acc       = rx_valid_i && !r_prev;
  assign w_to        = !w_acc && r_to == TO_W'(TIMEOUT_CYC - 1);
  assign w_clamp_col = 32'(rx_data_i) >= N_COL ? COL_W'(N_COL - 1) : COL_W'(rx_data_i);
  assign w_clamp_row = 32'(rx_data_i) >= N_ROW ? ROW_W'(N_ROW - 1) : ROW_W'(rx_data_i);
  assign w_col_end   = r_ccol == COL_W'(N_COL - 1);
  assign w_row_inc   = r_crow == ROW_W'(N_ROW - 1) ? '0 : r_crow + ROW_W'(1);
  console_clear_sweep #(.N_COL(N_COL), .N_ROW(N_ROW), .COL_W(COL_W), .ROW_W(ROW_W)) u_sweep (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(w_start),
    .busy_o(w_busy), .done_o(w_done), .col_o(w_scol), .row_o(w_srow)
  );
  // The sweep owns the write port while busy; both sources are registers.
  assign wr_en_o   = r_wr || w_busy;
  assign col_o     = w_busy ? w_scol : r_col;
  assign row_o     = w_busy ? w_srow : r_row;
  assign char_o    = w_busy ? CHAR_W'(FILL) : r_chr;
  assign attr_o    = w_busy ? r_attr : r_wattr;
  assign cur_col_o = r_ccol;
  assign cur_row_o = r_crow;
  assign busy_o    = w_busy;
  assign overrun_o = r_ovr;
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    if (r_state == S_CLEAR) w_next = w_done ? S_IDLE : S_CLEAR;
    else if (w_acc) begin
      case (r_state)
        S_IDLE:  w_next = rx_data_i == C_ESC ? S_ESC : S_IDLE;
        S_ESC: begin
          w_next  = rx_data_i == OP_P ? S_P_COL :
                    rx_data_i == OP_G ? S_G_COL :
                    rx_data_i == OP_A ? S_A_ATR :
                    rx_data_i == OP_C ? S_CLEAR : S_IDLE;
          w_start = rx_data_i == OP_C;
        end
        S_P_COL: w_next = S_P_ROW;
        S_P_ROW: w_next = S_P_CHR;
        S_P_CHR: w_next = S_P_ATR;
        S_G_COL: w_next = S_G_ROW;
        default: w_next = S_IDLE;
      endcase
    end else if (w_to && r_state != S_IDLE) w_next = S_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_prev  <= 1'b0;
      r_to    <= '0;
      r_wr    <= 1'b0;
      r_ovr   <= 1'b0;
      r_ccol  <= '0;
      r_crow  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_chr   <= '0;
      r_pcol  <= '0;
      r_prow  <= '0;
      r_pchr  <= '0;
      r_attr  <= DEFAULT_ATTR;
      r_wattr <= DEFAULT_ATTR;
    end else begin
      r_state <= w_next;
      r_prev  <= rx_valid_i;
      r_wr    <= 1'b0;
      r_ovr   <= w_acc && r_state == S_CLEAR;
      r_to    <= (r_state == S_IDLE || r_state == S_CLEAR || w_acc || w_to) ? '0 : r_to + TO_W'(1);
      if (r_state == S_CLEAR && w_done) begin
        r_ccol <= '0;
        r_crow <= '0;
      end
      if (w_acc) begin
        case (r_state)
          S_IDLE: begin
            if (is_print(rx_data_i)) begin
              r_wr    <= 1'b1;
              r_col   <= r_ccol;
              r_row   <= r_crow;
              r_chr   <= CHAR_W'(rx_data_i);
              r_wattr <= r_attr;
              r_ccol  <= w_col_end ? '0 : r_ccol + COL_W'(1);
              if (w_col_end) r_crow <= w_row_inc;
            end else if (rx_data_i == C_LF) begin
              r_ccol <= '0;
              r_crow <= w_row_inc;
            end else if (rx_data_i == C_CR) r_ccol <= '0;
            else if (rx_data_i == C_BS && r_ccol != '0) r_ccol <= r_ccol - COL_W'(1);
          end
          S_P_COL, S_G_COL: r_pcol <= w_clamp_col;
          S_P_ROW: r_prow <= w_clamp_row;
          S_P_CHR: r_pchr <= CHAR_W'(rx_data_i);
          S_P_ATR: begin
            r_wr    <= 1'b1;
            r_col   <= r_pcol;
            r_row   <= r_prow;
            r_chr   <= r_pchr;
            r_wattr <= ATTR_W'(rx_data_i);
          end
          S_G_ROW: begin
            r_ccol <= r_pcol;
            r_crow <= w_clamp_row;
          end
          S_A_ATR: r_attr <= ATTR_W'(rx_data_i);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: randomized byte stream checked against a command-level console model
module tb_text_console_ctrl;
  localparam int NC = 80;
  localparam int NR = 30;
  localparam int TO = 25_000;
  logic       clk = 1'b0;
  logic       rst_i, rx_valid_i;
  logic [7:0] rx_data_i;
  logic       wr_en_o, busy_o, overrun_o;
  logic [6:0] col_o, cur_col_o, char_o;
  logic [4:0] row_o, cur_row_o;
  logic [7:0] attr_o;
  always #5 clk = ~clk;
  text_console_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .wr_en_o(wr_en_o), .col_o(col_o), .row_o(row_o), .char_o(char_o), .attr_o(attr_o),
    .cur_col_o(cur_col_o), .cur_row_o(cur_row_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );
  int          n_cmp = 0, n_err = 0, busy_cnt = 0;
  logic [26:0] exp_q[$];
  logic [7:0]  cmd[$];
  int          cc = 0, cr = 0;
  logic [7:0]  attr = 8'h0F;
  bit          m_busy = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int lim(input int v, input int m);
    return v > m ? m : v;
  endfunction
  function automatic logic [26:0] wr(input int c, input int r, input logic [7:0] ch, input logic [7:0] a);
    return {7'(c), 5'(r), ch[6:0], a};
  endfunction
  task automatic model_byte(input logic [7:0] b);
    if (m_busy) return;
    if (cmd.size() == 0) begin
      if (b == 8'h1B) cmd.push_back(b);
      else if (b >= 8'h20 && b <= 8'h7E) begin
        exp_q.push_back(wr(cc, cr, b, attr));
        cc++;
        if (cc == NC) begin cc = 0; cr = (cr + 1) % NR; end
      end else if (b == 8'h0A) begin cc = 0; cr = (cr + 1) % NR; end
      else if (b == 8'h0D) cc = 0;
      else if (b == 8'h08 && cc > 0) cc--;
    end else begin
      cmd.push_back(b);
      case (cmd[1])
        8'h50: if (cmd.size() == 6) begin
          exp_q.push_back(wr(lim(int'(cmd[2]), NC-1), lim(int'(cmd[3]), NR-1), cmd[4], cmd[5]));
          cmd.delete();
        end
        8'h47: if (cmd.size() == 4) begin
          cc = lim(int'(cmd[2]), NC-1); cr = lim(int'(cmd[3]), NR-1);
          cmd.delete();
        end
        8'h41: if (cmd.size() == 3) begin attr = cmd[2]; cmd.delete(); end
        8'h43: begin
          for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) exp_q.push_back(wr(c, r, 8'h20, attr));
          cc = 0; cr = 0; m_busy = 1'b1;
          cmd.delete();
        end
        default: cmd.delete();
      endcase
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    bit drop;
    int hold, sz;
    drop = m_busy;
    hold = $urandom_range(1, 3);
    @(posedge clk); #1;
    rx_data_i = b; rx_valid_i = 1'b1;
    sz = exp_q.size();
    model_byte(b);
    @(posedge clk);
    @(negedge clk);
    chk("wr_lat", wr_en_o, (exp_q.size() > sz) || drop);
    chk("ovr", overrun_o, drop);
    if (!m_busy) chk("cursor", {cur_col_o, cur_row_o}, {7'(cc), 5'(cr)});
    repeat (hold - 1) @(negedge clk);
    rx_valid_i = 1'b0;
  endtask
  task automatic wait_sweep();
    int k = 0;
    while (busy_o && k < 3000) begin @(negedge clk); k++; end
    chk("busy_len", busy_cnt, NC*NR);
    chk("sweep_left", exp_q.size(), 0);
    chk("sweep_cur", {cur_col_o, cur_row_o}, {7'(cc), 5'(cr)});
    m_busy = 1'b0; busy_cnt = 0;
  endtask
  task automatic chk_reset();
    chk("rst_wr", wr_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_wport", {col_o, row_o, char_o, attr_o}, {7'd0, 5'd0, 7'd0, 8'h0F});
    chk("rst_cur", {cur_col_o, cur_row_o}, 0);
  endtask
  always @(negedge clk) if (!rst_i) begin
    if (busy_o) busy_cnt++;
    if (wr_en_o) begin
      chk("wr_expected", wr_en_o, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("wr", {col_o, row_o, char_o, attr_o}, exp_q.pop_front());
    end
  end
  initial begin
    logic [7:0] op;
    rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    rst_i = 1'b0;
    send_byte("H"); send_byte("i");
    send_byte(8'h1B); send_byte("G"); send_byte(8'd79); send_byte(8'd29);
    send_byte("Z");
    send_byte(8'h1B); send_byte("G"); send_byte(8'd0); send_byte(8'd29);
    send_byte(8'h0A);
    send_byte(8'h1B); send_byte("P"); send_byte(8'h05); send_byte(8'h63); send_byte("A"); send_byte(8'h1E);
    send_byte(8'h1B); send_byte("A"); send_byte(8'h2C);
    send_byte(8'h1B); send_byte("C");
    repeat (50) @(negedge clk);
    send_byte("Q");
    wait_sweep();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: send_byte(8'($urandom_range(32, 126)));
        6: case ($urandom_range(0, 4))
             0: send_byte(8'h0A);
             1: send_byte(8'h0D);
             2, 3: send_byte(8'h08);
             default: send_byte($urandom_range(0, 1) ? 8'h7F : 8'($urandom_range(0, 31)));
           endcase
        7: begin
          send_byte(8'h1B); send_byte("P");
          for (int j = 0; j < 4; j++) send_byte(8'($urandom_range(0, 255)));
        end
        8: begin
          send_byte(8'h1B); send_byte("G");
          send_byte(8'($urandom_range(0, 100))); send_byte(8'($urandom_range(0, 40)));
        end
        default: begin
          send_byte(8'h1B);
          op = $urandom_range(0, 1) ? "A" : 8'($urandom_range(0, 255));
          if (op == 8'h43) op = 8'h00;
          send_byte(op);
        end
      endcase
    end
    send_byte(8'h1B); send_byte("G"); send_byte(8'h0A);
    repeat (TO) @(posedge clk);
    cmd.delete();
    send_byte("x");
    send_byte(8'h1B); send_byte("C");
    while (busy_cnt < 100) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk_reset();
    rst_i = 1'b0;
    exp_q.delete(); cmd.delete();
    cc = 0; cr = 0; attr = 8'h0F; m_busy = 1'b0; busy_cnt = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy_o, 0);
    send_byte("k");
    repeat (5) @(negedge clk);
    chk("final_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
